// File: rtl/twiddle_addr_gen.sv
// Twiddle/butterfly address generator for one radix-2 stage of a 256-point FFT.
// Walks butterflies b = 0..127, emitting the data-memory index pair and the
// twiddle index k. o_rom_addr is combinational and looks one item ahead, so the
// 1-cycle ROM output always lines up with the registered index pair.
module twiddle_addr_gen (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_stage,
  input  logic       i_ready,
  output logic [6:0] o_rom_addr,
  output logic [7:0] o_idx_a,
  output logic [7:0] o_idx_b,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  typedef enum logic [1:0] {StIdle, StPrime, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [6:0] b_q, b_d;
  logic [3:0] stage_q, stage_d;
  logic [7:0] idx_a_q, idx_a_d;
  logic [7:0] idx_b_q, idx_b_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       xfer;
  logic       last;
  logic [6:0] b_inc;

  // h = 2^(s-1), the distance between the two legs of a butterfly
  function automatic logic [7:0] half_span(input logic [3:0] s);
    return 8'd1 << (s - 4'd1);
  endfunction

  // k = (b mod h) << (8-s)
  function automatic logic [6:0] calc_k(input logic [6:0] b, input logic [3:0] s);
    logic [6:0] j;
    j = b & 7'(half_span(s) - 8'd1);
    return j << (4'd8 - s);
  endfunction

  // idx_a = (b / h) * 2h + (b mod h)
  function automatic logic [7:0] calc_a(input logic [6:0] b, input logic [3:0] s);
    logic [7:0] b8;
    logic [7:0] j;
    logic [7:0] g2;
    b8 = {1'b0, b};
    j  = b8 & (half_span(s) - 8'd1);
    g2 = (b8 >> (s - 4'd1)) << s;
    return g2 + j;
  endfunction

  assign xfer  = valid_q && i_ready;
  assign last  = (b_q == 7'd127);
  assign b_inc = b_q + 7'd1;

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    stage_d = stage_q;
    idx_a_d = idx_a_q;
    idx_b_d = idx_b_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (i_start) begin
          if ((i_stage != 4'd0) && (i_stage <= 4'd8)) begin
            stage_d = i_stage;
            b_d     = 7'd0;
            state_d = StPrime;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StPrime: begin
        state_d = StRun;
        valid_d = 1'b1;
        idx_a_d = calc_a(7'd0, stage_q);
        idx_b_d = calc_a(7'd0, stage_q) + half_span(stage_q);
      end
      StRun: begin
        if (xfer) begin
          if (last) begin
            state_d = StDone;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            b_d     = b_inc;
            idx_a_d = calc_a(b_inc, stage_q);
            idx_b_d = calc_a(b_inc, stage_q) + half_span(stage_q);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      b_q     <= 7'd0;
      stage_q <= 4'd0;
      idx_a_q <= 8'd0;
      idx_b_q <= 8'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      stage_q <= stage_d;
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // ROM address looks ahead to the item that will be registered next edge
  always_comb begin
    o_rom_addr = 7'd0;
    unique case (state_q)
      StPrime: o_rom_addr = calc_k(7'd0, stage_q);
      StRun:   o_rom_addr = (xfer && !last) ? calc_k(b_inc, stage_q) : calc_k(b_q, stage_q);
      default: o_rom_addr = 7'd0;
    endcase
  end

  assign o_idx_a = idx_a_q;
  assign o_idx_b = idx_b_q;
  assign o_valid = valid_q;
  assign o_busy  = (state_q != StIdle);
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Self-checking bench for twiddle_addr_gen: table vectors, randomized stages
// against an arithmetic reference model, and hand-written corner sequences.
module tb_twiddle_addr_gen;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [3:0] i_stage;
  logic       i_ready;
  logic [6:0] o_rom_addr;
  logic [7:0] o_idx_a;
  logic [7:0] o_idx_b;
  logic       o_valid;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  logic [31:0] rom_q;

  int n_checks = 0;
  int n_errors = 0;

  int          obs_a   [128];
  int          obs_b   [128];
  logic [31:0] obs_rom [128];

  typedef struct {
    int s;
    int b;
    int ea;
    int eb;
    int ek;
  } vec_t;

  vec_t tbl[6];

  twiddle_addr_gen dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_stage    (i_stage),
    .i_ready    (i_ready),
    .o_rom_addr (o_rom_addr),
    .o_idx_a    (o_idx_a),
    .o_idx_b    (o_idx_b),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Angle ROM stand-in: one documented entry, every other word tags its index
  function automatic logic [31:0] rom_fn(input int k);
    if (k == 40) return 32'hBF7B53D1;
    return 32'hA5A50000 | 32'(k);
  endfunction

  always @(posedge i_clk) rom_q <= rom_fn(int'(o_rom_addr));

  // Reference: butterfly b of stage s, straight from the index formulas
  function automatic void model(input int s, input int b, output int a, output int bb,
                                output int k);
    int h;
    h  = 1 << (s - 1);
    a  = (b / h) * 2 * h + (b % h);
    bb = a + h;
    k  = (b % h) * (256 / (2 * h));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_addr"}, 32'(o_rom_addr), 0);
    check({tag, "_idx_a"}, 32'(o_idx_a), 0);
    check({tag, "_idx_b"}, 32'(o_idx_b), 0);
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_err"}, 32'(o_err), 0);
  endtask

  // Runs one full stage; records each transferred item into obs_*.
  task automatic run_stage(input int s, input int ready_pct, input int stall_at,
                           input bit poke_start);
    int cnt, edges, stall_n, ea, eb, ek, na, nb, nk;
    bit seen_done;
    i_stage = 4'(s);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_stage = 4'($urandom_range(0, 15));
    edges   = 1;
    model(s, 0, ea, eb, ek);
    check("prime_valid", 32'(o_valid), 0);
    check("prime_busy", 32'(o_busy), 1);
    check("prime_rom_addr", 32'(o_rom_addr), 32'(ek));
    cnt       = 0;
    stall_n   = 0;
    seen_done = 1'b0;
    while (!seen_done && edges < 2000) begin
      @(posedge i_clk); #1;
      edges++;
      if (o_done) begin
        seen_done = 1'b1;
        i_start   = 1'b0;
        i_ready   = 1'b0;
        check("done_item_count", 32'(cnt), 128);
        check("done_valid", 32'(o_valid), 0);
        check("done_busy", 32'(o_busy), 1);
        if (ready_pct == 100 && stall_at < 0) check("start_to_done", 32'(edges), 130);
      end else begin
        check("run_valid", 32'(o_valid), 1);
        check("run_busy", 32'(o_busy), 1);
        i_ready = ($urandom_range(0, 99) < ready_pct);
        if (cnt == stall_at && stall_n < 3) begin
          i_ready = 1'b0;
          stall_n++;
        end
        if (poke_start) begin
          i_start = 1'($urandom_range(0, 1));
          i_stage = 4'($urandom_range(0, 15));
        end
        #1;
        model(s, cnt, ea, eb, ek);
        check("run_idx_a", 32'(o_idx_a), 32'(ea));
        check("run_idx_b", 32'(o_idx_b), 32'(eb));
        check("run_rom_data", rom_q, rom_fn(ek));
        if (stall_at >= 0 && cnt == stall_at) begin
          check("stall_idx_a", 32'(o_idx_a), 40);
          check("stall_idx_b", 32'(o_idx_b), 168);
          check("stall_rom_data", rom_q, 32'hBF7B53D1);
        end
        if (i_ready && cnt < 127) model(s, cnt + 1, na, nb, nk);
        else nk = ek;
        check("run_rom_addr", 32'(o_rom_addr), 32'(nk));
        if (i_ready && cnt < 128) begin
          obs_a[cnt]   = int'(o_idx_a);
          obs_b[cnt]   = int'(o_idx_b);
          obs_rom[cnt] = rom_q;
          cnt++;
        end
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    i_start = 1'b0;
    i_ready = 1'b0;
    @(posedge i_clk); #1;
    check("post_done_pulse", 32'(o_done), 0);
    check("post_done_busy", 32'(o_busy), 0);
    check("post_done_valid", 32'(o_valid), 0);
  endtask

  task automatic try_illegal(input int s);
    i_stage = 4'(s);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("err_pulse", 32'(o_err), 1);
    check("err_busy", 32'(o_busy), 0);
    @(posedge i_clk); #1;
    check("err_one_cycle", 32'(o_err), 0);
    check("err_still_idle", 32'(o_busy), 0);
  endtask

  initial begin
    tbl[0] = '{s: 8, b: 0,   ea: 0,   eb: 128, ek: 0};
    tbl[1] = '{s: 8, b: 5,   ea: 5,   eb: 133, ek: 5};
    tbl[2] = '{s: 8, b: 127, ea: 127, eb: 255, ek: 127};
    tbl[3] = '{s: 1, b: 5,   ea: 10,  eb: 11,  ek: 0};
    tbl[4] = '{s: 1, b: 127, ea: 254, eb: 255, ek: 0};
    tbl[5] = '{s: 3, b: 5,   ea: 9,   eb: 13,  ek: 32};

    i_rst   = 1'b1;
    i_start = 1'b0;
    i_stage = 4'd0;
    i_ready = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check_all_zero("idle");

    // Table vectors: one full stage per distinct stage number
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || tbl[i].s != tbl[i-1].s) run_stage(tbl[i].s, 100, -1, 1'b0);
      check("tbl_idx_a", 32'(obs_a[tbl[i].b]), 32'(tbl[i].ea));
      check("tbl_idx_b", 32'(obs_b[tbl[i].b]), 32'(tbl[i].eb));
      check("tbl_rom", obs_rom[tbl[i].b], rom_fn(tbl[i].ek));
    end

    // Back-pressure at b=40 of stage 8
    run_stage(8, 100, 40, 1'b0);

    // Illegal stage numbers
    try_illegal(0);
    try_illegal(9);
    try_illegal($urandom_range(10, 15));

    // Randomized stages with random ready and ignored restarts
    for (int r = 0; r < 6; r++) begin
      run_stage($urandom_range(1, 8), $urandom_range(30, 100), -1, 1'b1);
    end

    // Reset mid-RUN at b=64, then restart
    i_stage = 4'd8;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_ready = 1'b1;
    repeat (65) @(posedge i_clk);
    #1;
    check("pre_reset_idx_a", 32'(o_idx_a), 64);
    check("pre_reset_valid", 32'(o_valid), 1);
    #2;
    i_rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (3) begin
      @(posedge i_clk); #1;
      check("reset_no_done", 32'(o_done), 0);
    end
    i_rst   = 1'b0;
    i_ready = 1'b0;
    @(posedge i_clk); #1;
    check_all_zero("after_reset");
    run_stage(8, 100, -1, 1'b0);
    check("restart_item0_a", 32'(obs_a[0]), 0);
    check("restart_item0_b", 32'(obs_b[0]), 128);
    check("restart_item0_rom", obs_rom[0], rom_fn(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/twiddle_addr_gen.md
TWIDDLE_ADDR_GEN -- requirements
Module: twiddle_addr_gen

Interface
REQ-001 SHALL expose: i_clk  input  1  sole clock, rising-edge.
REQ-002 SHALL expose: i_rst  input  1  asynchronous active-high reset.
REQ-003 SHALL expose: i_start  input  1  single-cycle request to sequence one stage; sampled only in IDLE.
REQ-004 SHALL expose: i_stage  input  4  radix-2 stage number s, legal 1..8 (256-point FFT); latched on accepted i_start.
REQ-005 SHALL expose: i_ready  input  1  downstream butterfly accepts current item.
REQ-006 SHALL expose: o_rom_addr  output  7  twiddle index k to the 7-bit, 1-cycle-latency registered angle ROM (angle = -2*pi*k/256).
REQ-007 SHALL expose: o_idx_a, o_idx_b  output  8 each  data-memory indices of the butterfly pair.
REQ-008 SHALL expose: o_valid  output  1  item on o_idx_a/o_idx_b is valid; ROM output matches it this cycle.
REQ-009 SHALL expose: o_busy  output  1  high in any state other than IDLE.
REQ-010 SHALL expose: o_done  output  1  one-cycle pulse after last transfer.
REQ-011 SHALL expose: o_err  output  1  one-cycle pulse on start with illegal stage.

Function
REQ-012 SHALL implement FSM IDLE -> PRIME -> RUN -> DONE -> IDLE; all outputs except o_rom_addr registered.
REQ-013 Butterfly counter b SHALL run 0..127; h = 2^(s-1); g = b >> (s-1); j = b & (h-1).
REQ-014 For item b: idx_a = g*2h + j, idx_b = idx_a + h, k = j << (8-s); all arithmetic unsigned, 8-bit, no overflow for legal s.
REQ-015 IDLE: o_valid=0, o_busy=0, o_rom_addr=0; i_start with 1<=i_stage<=8 latches stage, clears b, goes PRIME.
REQ-016 IDLE: i_start with i_stage 0 or 9..15 SHALL pulse o_err next cycle and remain IDLE.
REQ-017 PRIME (exactly one cycle): o_rom_addr = k(0), o_valid=0; next state RUN with o_idx_a/o_idx_b = item 0, o_valid=1.
REQ-018 RUN: o_valid=1; indices SHALL hold stable while i_ready=0.
REQ-019 RUN: o_rom_addr combinational = k(b+1) when o_valid&&i_ready and b<127, else k(b), so ROM output always matches registered indices one cycle later with no bubble.
REQ-020 Transfer = o_valid && i_ready; on transfer with b<127, b increments and indices update to item b+1 next cycle.
REQ-021 Transfer with b=127 SHALL go DONE: o_valid=0, o_done=1 for one cycle, then IDLE.
REQ-022 i_start in PRIME/RUN/DONE SHALL be ignored; i_stage changes after latch SHALL have no effect.
REQ-023 Throughput SHALL be one item per cycle with i_ready=1; 128 transfers per stage; start-to-done = 130 cycles (start edge, PRIME, 128 RUN cycles, then done).

Reset
REQ-024 i_rst high SHALL immediately force IDLE, b=0, latched stage=0, o_valid=0, o_busy=0, o_done=0, o_err=0, o_idx_a=0, o_idx_b=0, o_rom_addr=0.
REQ-025 Reset asserted mid-RUN SHALL abort the stage with no o_done; first i_start after deassertion SHALL restart at b=0.

Verification
REQ-026 Stage 8, i_ready=1: items b=0,5,127 -> (idx_a,idx_b,k) = (0,128,0),(5,133,5),(127,255,127); o_done 130 cycles after start.
REQ-027 Stage 1: b=5 -> (10,11,0); b=127 -> (254,255,0); stage 3: b=5 -> (9,13,32).
REQ-028 Stage 8, i_ready low 3 cycles at b=40 -> indices (40,168) and ROM data 0xBF7B53D1 held stable; b=41 follows without bubble when i_ready returns high.
REQ-029 i_start with i_stage=0 and with i_stage=9 -> o_err pulse, o_busy stays 0; second i_start during RUN -> ignored, sequence unchanged.
REQ-030 Assert i_rst at b=64 of stage 8 -> all outputs 0 asynchronously, no o_done; restart yields item 0 = (0,128,0).
